// File: rtl/lane_deserializer_if.sv
// Bit-stream input and word-output bundle of the lane deserializer.
// master drives the serial side; slave is the deserializer itself.
interface lane_deserializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             data_in;
    logic             enable;
    logic             align_rst;
    logic [WIDTH-1:0] parallel_data;
    logic             data_valid;
    logic             busy;
    logic [CNT_W-1:0] word_count;

    modport master (
        output data_in,
        output enable,
        output align_rst,
        input  parallel_data,
        input  data_valid,
        input  busy,
        input  word_count
    );

    modport slave (
        input  data_in,
        input  enable,
        input  align_rst,
        output parallel_data,
        output data_valid,
        output busy,
        output word_count
    );
endinterface

// File: rtl/lane_deserializer.sv
// Packs the descrambled serial stream into WIDTH-bit words with a one-cycle valid strobe,
// tracking word alignment and counting completed words since enable last rose.
module lane_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input logic               clk,
    input logic               rst,
    lane_deserializer_if.slave bus
);
    localparam int unsigned IdxW = $clog2(WIDTH);

    typedef logic [IdxW-1:0]  idx_t;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [CNT_W-1:0] count_t;

    localparam idx_t LastBit = idx_t'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StCollect} state_t;

    state_t state_q, state_d;
    idx_t   bit_cnt_q, bit_cnt_d;
    word_t  shift_q, shift_d;
    word_t  pdata_q, pdata_d;
    logic   valid_q, valid_d;
    count_t count_q, count_d;

    // Received bit k maps to word bit k, or WIDTH-1-k when MSB_FIRST.
    function automatic idx_t place(input idx_t k);
        if (MSB_FIRST) begin
            return LastBit - k;
        end
        return k;
    endfunction

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        valid_d   = 1'b0;
        count_d   = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    shift_d              = '0;
                    shift_d[place('0)]   = bus.data_in;
                    bit_cnt_d            = idx_t'(1);
                    count_d              = '0;
                    state_d              = StCollect;
                end
            end
            StCollect: begin
                if (!bus.enable) begin
                    // Partial word is dropped; output word and count are kept.
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (bus.align_rst) begin
                    // Realign wins over completion: current bit opens a new word.
                    shift_d            = '0;
                    shift_d[place('0)] = bus.data_in;
                    bit_cnt_d          = idx_t'(1);
                end else if (bit_cnt_q == LastBit) begin
                    pdata_d                   = shift_q;
                    pdata_d[place(bit_cnt_q)] = bus.data_in;
                    valid_d                   = 1'b1;
                    count_d                   = count_q + count_t'(1);
                    bit_cnt_d                 = '0;
                    shift_d                   = '0;
                end else begin
                    shift_d[place(bit_cnt_q)] = bus.data_in;
                    bit_cnt_d                 = bit_cnt_q + idx_t'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign bus.parallel_data = pdata_q;
    assign bus.data_valid    = valid_q;
    assign bus.busy          = (state_q == StCollect) && (bit_cnt_q != '0);
    assign bus.word_count    = count_q;
endmodule

// File: tb/tb_lane_deserializer.sv
// Drives LSB-first and MSB-first deserializers with one shared bit stream and checks
// both against a queue-based word-assembly model every cycle.
module tb_lane_deserializer;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    lane_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus_lsb ();
    lane_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus_msb ();

    lane_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(CW)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_lsb)
    );

    lane_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(CW)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_msb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: collected bits of the current word, in arrival order.
    logic          q_bits[$];
    bit            active;
    logic [W-1:0]  m_lsb;
    logic [W-1:0]  m_msb;
    logic          m_valid;
    logic [CW-1:0] m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        active  = 1'b0;
        m_lsb   = '0;
        m_msb   = '0;
        m_valid = 1'b0;
        m_count = '0;
    endtask

    task automatic model_step(input logic d, input logic en, input logic ar);
        m_valid = 1'b0;
        if (!en) begin
            active = 1'b0;
            q_bits.delete();
        end else if (!active || ar) begin
            if (!active) m_count = '0;
            active = 1'b1;
            q_bits.delete();
            q_bits.push_back(d);
        end else begin
            q_bits.push_back(d);
            if (q_bits.size() == W) begin
                for (int k = 0; k < W; k++) begin
                    m_lsb[k]       = q_bits[k];
                    m_msb[W-1-k]   = q_bits[k];
                end
                m_valid = 1'b1;
                m_count = m_count + 1'b1;
                q_bits.delete();
            end
        end
    endtask

    task automatic check_all();
        logic m_busy;
        m_busy = active && (q_bits.size() != 0);
        chk("pdata_lsb", 32'(bus_lsb.parallel_data), 32'(m_lsb));
        chk("pdata_msb", 32'(bus_msb.parallel_data), 32'(m_msb));
        chk("valid_lsb", 32'(bus_lsb.data_valid), 32'(m_valid));
        chk("valid_msb", 32'(bus_msb.data_valid), 32'(m_valid));
        chk("busy_lsb", 32'(bus_lsb.busy), 32'(m_busy));
        chk("busy_msb", 32'(bus_msb.busy), 32'(m_busy));
        chk("count_lsb", 32'(bus_lsb.word_count), 32'(m_count));
        chk("count_msb", 32'(bus_msb.word_count), 32'(m_count));
    endtask

    task automatic drive(input logic d, input logic en, input logic ar);
        bus_lsb.data_in   = d;
        bus_lsb.enable    = en;
        bus_lsb.align_rst = ar;
        bus_msb.data_in   = d;
        bus_msb.enable    = en;
        bus_msb.align_rst = ar;
    endtask

    task automatic step(input logic d, input logic en, input logic ar);
        drive(d, en, ar);
        @(posedge clk);
        if (rst) model_step(d, en, ar);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic ar_first);
        for (int k = 0; k < W; k++) step(w[k], 1'b1, ar_first && (k == 0));
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 1'b0);

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        repeat (20) step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1));
        chk("idle_pdata", 32'(bus_lsb.parallel_data), 32'h0);

        // Single word, both bit orders
        send_word(8'h4D, 1'b0);
        chk("lsb_word", 32'(bus_lsb.parallel_data), 32'h4D);
        chk("msb_word", 32'(bus_msb.parallel_data), 32'hB2);
        chk("first_valid", 32'(bus_lsb.data_valid), 32'h1);
        chk("first_count", 32'(bus_lsb.word_count), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back words
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        chk("b2b_word", 32'(bus_lsb.parallel_data), 32'h44);
        chk("b2b_count", 32'(bus_lsb.word_count), 32'h4);

        // Mid-word drop
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step($urandom_range(0, 1), 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        send_word(8'hA5, 1'b0);
        chk("drop_word", 32'(bus_lsb.parallel_data), 32'hA5);
        chk("drop_count", 32'(bus_lsb.word_count), 32'h1);

        // Realign mid-word, then realign on a completion cycle
        for (int k = 0; k < 6; k++) step($urandom_range(0, 1), 1'b1, 1'b0);
        send_word(8'h3C, 1'b1);
        chk("realign_word", 32'(bus_lsb.parallel_data), 32'h3C);
        chk("realign_count", 32'(bus_lsb.word_count), 32'h2);
        for (int k = 0; k < W - 1; k++) step($urandom_range(0, 1), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("ar_complete_valid", 32'(bus_lsb.data_valid), 32'h0);
        chk("ar_complete_count", 32'(bus_lsb.word_count), 32'h2);

        // Asynchronous reset between edges, mid-word
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0);
        chk("post_rst_word", 32'(bus_lsb.parallel_data), 32'h5A);

        // Counter wrap over a long continuous run
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) send_word(W'($urandom), 1'b0);
        chk("wrap_count", 32'(bus_lsb.word_count), 32'h4);

        // Random traffic with occasional drops and realigns
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, 31) != 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lane_deserializer.md
Name: lane_deserializer

Overview:
Serial-to-parallel stage directly downstream of the lane descrambler. It consumes the descrambled bit stream (data_out / enable_deser of the descrambler) and packs it into WIDTH-bit words, one valid strobe per word. It tracks word-boundary alignment, discards partial words when the stream drops or is re-aligned, and counts completed words for the link-layer logic above it.

Parameters:
WIDTH, 8, bits per output word; legal range 2..132.
MSB_FIRST, 0, 0 = first received bit lands in word bit 0; 1 = first received bit lands in word bit WIDTH-1.
CNT_W, 16, width of word_count.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
data_in  input  1  descrambled serial bit; valid only when enable=1.
enable  input  1  bit-valid qualifier from the descrambler (enable_deser).
align_rst  input  1  word-boundary restart; sampled only when enable=1.
parallel_data  output  WIDTH  last completed word; held until the next word completes.
data_valid  output  1  one-cycle pulse, asserted in the cycle parallel_data updates.
busy  output  1  1 while a word is partially collected (state COLLECT, bit_cnt != 0).
word_count  output  CNT_W  words completed since enable last rose; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit_cnt=0, parallel_data=0, data_valid=0, busy=0, word_count=0. All state bits are cleared immediately, including mid-word.
- Registered outputs only; no combinational path from inputs to outputs.
- States:
  - IDLE: enable=0. On a cycle with enable=1, sample data_in as bit index 0, set bit_cnt=1, move to COLLECT, clear word_count.
  - COLLECT: each cycle with enable=1, store data_in at bit index bit_cnt and increment bit_cnt.
- Bit placement: received bit k (k=0..WIDTH-1) goes to word bit k when MSB_FIRST=0, and to word bit WIDTH-1-k when MSB_FIRST=1.
- Word completion: when bit_cnt==WIDTH-1 and enable=1, on the same edge:
  - parallel_data <= the full word including the current bit;
  - data_valid <= 1;
  - bit_cnt <= 0;
  - word_count increments.
  - Latency: data_valid is high the cycle after the edge that sampled the WIDTH-th bit.
- data_valid is high for exactly one cycle per word. For back-to-back words it is high every WIDTH cycles with no gaps and no lost bits.
- enable falls (enable=0) in COLLECT:
  - the partial word is discarded; state returns to IDLE and bit_cnt=0;
  - data_valid=0 and busy=0;
  - parallel_data and word_count hold their values.
- align_rst=1 with enable=1:
  - the current data_in is treated as bit index 0 of a new word and bit_cnt becomes 1;
  - the partial word is discarded with no data_valid;
  - word_count is unchanged.
- align_rst=1 on the completion cycle (bit_cnt==WIDTH-1): align_rst has priority. No word is emitted and the current bit starts a new word.
- align_rst with enable=0 is ignored.
- word_count at 2^CNT_W-1 wraps to 0 on the next completion.
- busy=1 exactly when state=COLLECT and bit_cnt != 0.

Test Plan:
- Reset then idle: rst low for 2 cycles, enable=0 for 20 cycles -> parallel_data=0x00, data_valid=0, busy=0, word_count=0 throughout.
- LSB-first word: WIDTH=8, MSB_FIRST=0, enable=1, bits 1,0,1,1,0,0,1,0 -> one cycle after the 8th bit, parallel_data=0x4D, data_valid high for 1 cycle, word_count=1. The same stream with MSB_FIRST=1 -> parallel_data=0xB2.
- Back-to-back: 32 continuous bits encoding 0x11,0x22,0x33,0x44 (LSB-first) -> four data_valid pulses exactly 8 cycles apart, words in order, word_count=4.
- Mid-word drop: 5 bits, then enable=0 for 3 cycles, then 8 bits of 0xA5 -> no strobe for the partial word, single output 0xA5, word_count=1 (cleared on the enable rise).
- Realign: 6 bits, then align_rst=1 on the 7th bit, followed by 7 more bits forming 0x3C with the 7th as bit 0 -> exactly one word 0x3C. align_rst on a completion cycle -> no strobe that cycle.
- Async reset mid-word: assert rst after 4 bits, between clock edges -> all outputs 0 immediately. After release, a full 0x5A word is emitted correctly.
